// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between I-cache and D-cache block requests.
// Sequences one memory transaction at a time, with timeout and sticky error.
module mem_arbiter #(
  parameter int AWIDTH  = 23,
  parameter int DWIDTH  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [AWIDTH-1:0] ic_addr,
  output logic [DWIDTH-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [AWIDTH-1:0] dc_addr,
  input  logic [DWIDTH-1:0] dc_wdata,
  output logic [DWIDTH-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              last_dc_q, last_dc_d;
  logic              own_dc_q, own_dc_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] ic_rdata_q, ic_rdata_d;
  logic [DWIDTH-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_done_q, ic_done_d;
  logic              dc_done_q, dc_done_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;
  logic              err_q, err_d;

  logic any_req;
  logic pick_dc;
  logic win_we;
  logic in_busy;
  logic fin_ok;
  logic fin_tmo;

  // Ties go to the port that did not win last time.
  assign any_req = ic_req | dc_req;
  assign pick_dc = dc_req & (~ic_req | ~last_dc_q);
  assign win_we  = pick_dc & dc_we;
  assign in_busy = (state_q == BUSY);
  assign fin_ok  = in_busy & mem_ready;
  assign fin_tmo = in_busy & ~mem_ready & (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = BUSY;
      end
      BUSY: begin
        if (fin_ok | fin_tmo) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    last_dc_d  = last_dc_q;
    own_dc_d   = own_dc_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_done_d  = 1'b0;
    dc_done_d  = 1'b0;
    rden_d     = 1'b0;
    wren_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          last_dc_d = pick_dc;
          own_dc_d  = pick_dc;
          we_d      = win_we;
          cnt_d     = '0;
          addr_d    = pick_dc ? dc_addr : ic_addr;
          wdata_d   = pick_dc ? dc_wdata : '0;
          rden_d    = ~win_we;
          wren_d    = win_we;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (fin_ok | fin_tmo) begin
          ic_done_d = ~own_dc_q;
          dc_done_d = own_dc_q;
          if (fin_tmo) begin
            err_d = 1'b1;
            if (own_dc_q) dc_rdata_d = '0;
            else          ic_rdata_d = '0;
          end else if (!we_q) begin
            if (own_dc_q) dc_rdata_d = mem_rdata;
            else          ic_rdata_d = mem_rdata;
          end
        end else begin
          rden_d = ~we_q;
          wren_d = we_q;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dc_q  <= 1'b0;
      own_dc_q   <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_dc_q  <= last_dc_d;
      own_dc_q   <= own_dc_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_done_q  <= ic_done_d;
      dc_done_q  <= dc_done_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      err_q      <= err_d;
    end
  end

  assign ic_rdata  = ic_rdata_q;
  assign ic_done   = ic_done_q;
  assign dc_rdata  = dc_rdata_q;
  assign dc_done   = dc_done_q;
  assign mem_rden  = rden_q;
  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against
// a transaction-level model of arbitration, memory contents and results.
module tb_mem_arbiter;

  localparam int AW  = 23;
  localparam int DW  = 128;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] dc_rdata;
  logic          dc_done;
  logic          mem_rden;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  mem_arbiter #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_rdata (ic_rdata),
    .ic_done  (ic_done),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_rdata (dc_rdata),
    .dc_done  (dc_done),
    .mem_rden (mem_rden),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] ic_exp;
  logic [DW-1:0] dc_exp;
  bit            err_exp;
  bit            last_dc;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] pool_addr();
    return AW'($urandom_range(0, 15));
  endfunction

  // Strobe exclusivity and minimum low gap between strobe runs.
  int low_run = 100;
  always @(negedge clk) begin
    if (rst) begin
      low_run = 100;
    end else begin
      check("strobe_excl", mem_rden & mem_wren, 0);
      if (mem_rden | mem_wren) begin
        if (low_run > 0 && low_run < 100)
          check("strobe_gap", low_run >= 2, 1);
        low_run = 0;
      end else if (low_run < 100) begin
        low_run++;
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    ic_req    = 1'b0;
    dc_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst     = 1'b0;
    ic_exp  = '0;
    dc_exp  = '0;
    err_exp = 1'b0;
    last_dc = 1'b0;
  endtask

  // Serve one granted transaction: memory answers in BUSY cycle 'lat'
  // (0-based) unless tmo, then check the done cycle and return to idle.
  task automatic expect_txn(input bit is_dc, input bit we,
                            input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int lat,
                            input bit tmo, input bit drop);
    int n;
    logic [DW-1:0] rd;
    n = 0;
    while (!(mem_rden | mem_wren) && n < 20) begin
      step();
      n++;
    end
    check("grant_seen", mem_rden | mem_wren, 1);
    check("mem_addr", mem_addr, addr);
    check("mem_wren", mem_wren, we);
    check("mem_rden", mem_rden, !we);
    if (we) check("mem_wdata", mem_wdata, wd);
    rd = '0;
    if (!we) begin
      if (mem_model.exists(addr)) rd = mem_model[addr];
      else rd = rnd();
    end
    n = 0;
    while ((mem_rden | mem_wren) && n < 200) begin
      if (!tmo && n == lat) begin
        mem_ready = 1'b1;
        mem_rdata = we ? rnd() : rd;
      end
      step();
      mem_ready = 1'b0;
      mem_rdata = rnd();
      n++;
    end
    check("busy_len", n, tmo ? TMO : lat + 1);
    if (tmo) begin
      err_exp = 1'b1;
      if (is_dc) dc_exp = '0;
      else       ic_exp = '0;
    end else if (we) begin
      mem_model[addr] = wd;
    end else begin
      mem_model[addr] = rd;
      if (is_dc) dc_exp = rd;
      else       ic_exp = rd;
    end
    check("done_strobes", {mem_rden, mem_wren}, 0);
    check("ic_done", ic_done, !is_dc);
    check("dc_done", dc_done, is_dc);
    check("ic_rdata", ic_rdata, ic_exp);
    check("dc_rdata", dc_rdata, dc_exp);
    check("err", err, err_exp);
    last_dc = is_dc;
    if (drop) begin
      if (is_dc) dc_req = 1'b0;
      else       ic_req = 1'b0;
    end
    step();
    check("done_clr", {ic_done, dc_done}, 0);
    check("idle_strobes", {mem_rden, mem_wren}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a_ic;
    logic [AW-1:0] a_dc;
    int k;
    rst       = 1'b1;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    do_reset();

    check("rst_rden", mem_rden, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_ic_done", ic_done, 0);
    check("rst_dc_done", dc_done, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ic_rdata", ic_rdata, 0);
    check("rst_dc_rdata", dc_rdata, 0);

    // Single I-cache read with known data.
    mem_model[23'h000010] = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
    ic_addr = 23'h000010;
    ic_req  = 1'b1;
    expect_txn(0, 0, 23'h000010, '0, 2, 0, 1);
    check("t1_ic_rdata", ic_rdata, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001);

    // D-cache writeback at the top address.
    dc_addr  = 23'h7FFFFF;
    dc_we    = 1'b1;
    dc_wdata = '1;
    dc_req   = 1'b1;
    expect_txn(1, 1, 23'h7FFFFF, '1, $urandom_range(0, 3), 0, 1);
    dc_we = 1'b0;

    // Simultaneous requests after reset: D, I, then D again.
    do_reset();
    a_ic    = pool_addr();
    a_dc    = pool_addr() | 23'h100;
    ic_addr = a_ic;
    dc_addr = a_dc;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    expect_txn(1, 0, a_dc, '0, 1, 0, 1);
    dc_req = 1'b1;
    expect_txn(0, 0, a_ic, '0, 0, 0, 0);
    expect_txn(1, 0, a_dc, '0, 2, 0, 1);
    expect_txn(0, 0, a_ic, '0, 0, 0, 1);

    // Timeout on a read, then err stays set through a good transaction.
    ic_addr = 23'h000123;
    ic_req  = 1'b1;
    expect_txn(0, 0, 23'h000123, '0, 0, 1, 1);
    dc_addr = pool_addr();
    dc_req  = 1'b1;
    expect_txn(1, 0, dc_addr, '0, 1, 0, 1);
    check("err_sticky", err, 1);

    // Reset two cycles into BUSY.
    ic_addr = 23'h000456;
    ic_req  = 1'b1;
    k = 0;
    while (!mem_rden && k < 10) begin
      step();
      k++;
    end
    check("rst_mid_grant", mem_rden, 1);
    step();
    rst = 1'b1;
    step();
    check("rst_mid_strobes", {mem_rden, mem_wren}, 0);
    check("rst_mid_done", {ic_done, dc_done}, 0);
    check("rst_mid_err", err, 0);
    rst     = 1'b0;
    ic_req  = 1'b0;
    ic_exp  = '0;
    dc_exp  = '0;
    err_exp = 1'b0;
    last_dc = 1'b0;
    step();
    check("rst_mid_idle", {mem_rden, mem_wren, ic_done, dc_done}, 0);
    dc_addr = 23'h000042;
    dc_req  = 1'b1;
    expect_txn(1, 0, 23'h000042, '0, 0, 0, 1);

    // I-cache drops req right after the grant.
    ic_addr = 23'h000777;
    ic_req  = 1'b1;
    step();
    check("drop_grant", mem_rden, 1);
    ic_req = 1'b0;
    expect_txn(0, 0, 23'h000777, '0, 3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop_no_regrant", {mem_rden, mem_wren, ic_done}, 0);
    end

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 40; it++) begin
      int sel;
      bit ra;
      bit rb;
      bit w;
      bit wwe;
      if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rnd();
        step();
        mem_ready = 1'b0;
        check("stray_ready", {ic_done, dc_done, mem_rden, mem_wren}, 0);
      end
      sel      = $urandom_range(1, 3);
      ra       = sel[0];
      rb       = sel[1];
      ic_addr  = pool_addr();
      dc_addr  = pool_addr();
      dc_we    = 1'($urandom_range(0, 1));
      dc_wdata = rnd();
      ic_req   = ra;
      dc_req   = rb;
      w        = rb && (!ra || !last_dc);
      wwe      = w ? dc_we : 1'b0;
      expect_txn(w, wwe, w ? dc_addr : ic_addr, dc_wdata,
                 $urandom_range(0, 4), 0, 1);
      if (ra && rb) begin
        wwe = !w ? dc_we : 1'b0;
        expect_txn(!w, wwe, !w ? dc_addr : ic_addr, dc_wdata,
                   $urandom_range(0, 4), 0, 1);
      end
      dc_we = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
